// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT front end: default sample width,
// frame size and the frame loader state encoding.
package fft_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int FFT_N          = 4;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t ST_FILL    = 2'd0;
  localparam loader_state_t ST_ISSUE   = 2'd1;
  localparam loader_state_t ST_RUN     = 2'd2;
  localparam loader_state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/fft_frame_loader.sv
// Collects a serial valid/ready sample stream into 4-sample frames, hands each
// frame to the FFT core with a level start, and guards the core with a watchdog.
module fft_frame_loader #(
  parameter int DATA_W  = fft_pkg::DEFAULT_DATA_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] sample0_out,
  output logic [DATA_W-1:0] sample1_out,
  output logic [DATA_W-1:0] sample2_out,
  output logic [DATA_W-1:0] sample3_out,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              frame_done,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  frame_count
);

  import fft_pkg::*;

  // The watchdog only needs to reach TIMEOUT-1 before it fires.
  localparam int WD_W = $clog2(TIMEOUT);

  loader_state_t     state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] sample_q [FFT_N];
  logic [DATA_W-1:0] sample_d [FFT_N];
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              fdone_q, fdone_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              wdog_hit;

  assign wdog_hit = (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    wdog_d   = wdog_q;
    count_d  = count_q;
    err_d    = err_q;
    fdone_d  = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          sample_d[idx_q] = in_data;
          idx_d           = idx_q + 2'd1;
          if (idx_q == 2'(FFT_N - 1)) begin
            state_d = ST_ISSUE;
            wdog_d  = '0;
          end
        end
      end
      ST_ISSUE, ST_RUN: begin
        wdog_d = wdog_q + 1'b1;
        // A real completion wins over a watchdog expiry in the same cycle.
        if (state_q == ST_RUN && fft_done) begin
          state_d = ST_RELEASE;
          fdone_d = 1'b1;
          count_d = count_q + 1'b1;
        end else if (wdog_hit) begin
          state_d = ST_RELEASE;
          err_d   = 1'b1;
        end else if (state_q == ST_ISSUE && !fft_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RELEASE: state_d = ST_FILL;
      default:    state_d = ST_FILL;
    endcase
    start_d = (state_d == ST_ISSUE) || (state_d == ST_RUN);
    busy_d  = start_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FILL;
      idx_q    <= '0;
      sample_q <= '{default: '0};
      wdog_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      fdone_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      wdog_q   <= wdog_d;
      count_q  <= count_d;
      err_q    <= err_d;
      fdone_q  <= fdone_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready    = (state_q == ST_FILL);
  assign sample0_out = sample_q[0];
  assign sample1_out = sample_q[1];
  assign sample2_out = sample_q[2];
  assign sample3_out = sample_q[3];
  assign fft_start   = start_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign timeout_err = err_q;
  assign frame_count = count_q;

endmodule
